// File: rtl/ping_pong_monitor.sv
// ping_pong_monitor: passive checker for a ping-pong counter output stream.
// Rebuilds the legal next (out, direction) from last cycle's snapshot, counts
// boundary bounces and mid-range flips, and flags illegal steps.
// Optional build macro: PPM_RESYNC_EN -- when defined, FAULT lasts one cycle and
// the monitor re-locks; when undefined, FAULT holds until reset.
module ping_pong_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic             direction,
    input  logic [WIDTH-1:0] out,
    output logic             locked,
    output logic             flip_det,
    output logic             bounce_det,
    output logic [CNT_W-1:0] flip_cnt,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] p_out, p_max, p_min;
    logic             p_dir, p_en;

    logic [WIDTH-1:0] inc, dec;
    logic active, up_ok, dn_ok, mid;
    logic step_up, step_dn;
    logic is_hold, is_normal, is_bounce, is_flip, legal;
    logic flip_next, bounce_next, err_next;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Snapshot of last cycle's stream and sideband; pure data, no reset needed.
    always_ff @(posedge clk) begin
        p_out <= out;
        p_dir <= direction;
        p_en  <= enable;
        p_max <= max;
        p_min <= min;
    end

    // Classify the current (out, direction) against the snapshot.
    always_comb begin
        inc     = p_out + 1'b1;
        dec     = p_out - 1'b1;
        active  = p_en && (p_max > p_min) && (p_out >= p_min) && (p_out <= p_max);
        up_ok   = p_out < p_max;
        dn_ok   = p_out > p_min;
        mid     = up_ok && dn_ok;
        step_up = (out == inc) && direction;
        step_dn = (out == dec) && !direction;
        // inc/dec are only consulted where the bound guarantees no wrap.
        is_hold   = !active && (out == p_out) && (direction == p_dir);
        is_normal = active && ((p_dir && up_ok && step_up) || (!p_dir && dn_ok && step_dn));
        is_bounce = active && ((p_dir && (p_out == p_max) && step_dn) ||
                               (!p_dir && (p_out == p_min) && step_up));
        // A reversal at a boundary looks like a bounce/normal step, so flips are mid-range only.
        is_flip   = active && mid && ((p_dir && step_dn) || (!p_dir && step_up));
        legal     = is_hold || is_normal || is_bounce || is_flip;
    end

    // Next-state and next-output logic for the tracking FSM.
    always_comb begin
        state_next  = state;
        flip_next   = 1'b0;
        bounce_next = 1'b0;
        err_next    = err;
        case (state)
            SYNC: begin
                state_next = TRACK;
            end
            TRACK: begin
                if (legal) begin
                    flip_next   = is_flip;
                    bounce_next = is_bounce;
                end else begin
                    err_next   = 1'b1;
                    state_next = FAULT;
                end
            end
            FAULT: begin
`ifdef PPM_RESYNC_EN
                state_next = TRACK;
`else
                state_next = FAULT;
`endif
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    // State and registered status outputs; reset wins over every other condition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SYNC;
            flip_det   <= 1'b0;
            bounce_det <= 1'b0;
            err        <= 1'b0;
            flip_cnt   <= '0;
            bounce_cnt <= '0;
        end else begin
            state      <= state_next;
            flip_det   <= flip_next;
            bounce_det <= bounce_next;
            err        <= err_next;
            if (flip_next) begin
                flip_cnt <= sat_inc(flip_cnt);
            end
            if (bounce_next) begin
                bounce_cnt <= sat_inc(bounce_cnt);
            end
        end
    end

    assign locked = (state == TRACK);

endmodule

// File: tb/tb_ping_pong_monitor.sv
// Self-checking bench for ping_pong_monitor: hand-classified stimulus steps push
// expected outputs into a scoreboard that is popped after each clock edge.
// Two instances share the inputs: default counters and CNT_W=2 for saturation.
module tb_ping_pong_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       direction;
    logic [3:0] max_v, min_v, out_v;

    logic       locked, flip_det, bounce_det, err;
    logic [7:0] flip_cnt, bounce_cnt;
    logic       s_locked, s_flip_det, s_bounce_det, s_err;
    logic [1:0] s_flip_cnt, s_bounce_cnt;

    typedef enum int {EV_N, EV_F, EV_B, EV_E} ev_t;
    typedef enum int {M_SYNC, M_TRACK, M_FAULT} mst_t;
    typedef struct {
        int lk;
        int fl;
        int bo;
        int er;
        int fc;
        int bc;
    } exp_t;

    exp_t sb[$];
    mst_t mst;
    int   m_err, m_fc, m_bc;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ping_pong_monitor #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .max(max_v), .min(min_v),
        .direction(direction), .out(out_v), .locked(locked), .flip_det(flip_det),
        .bounce_det(bounce_det), .flip_cnt(flip_cnt), .bounce_cnt(bounce_cnt), .err(err)
    );

    ping_pong_monitor #(.WIDTH(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .max(max_v), .min(min_v),
        .direction(direction), .out(out_v), .locked(s_locked), .flip_det(s_flip_det),
        .bounce_det(s_bounce_det), .flip_cnt(s_flip_cnt), .bounce_cnt(s_bounce_cnt), .err(s_err)
    );

    task automatic check(input string tag, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, act, want, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check("locked",     int'(locked),       e.lk);
            check("flip_det",   int'(flip_det),     e.fl);
            check("bounce_det", int'(bounce_det),   e.bo);
            check("err",        int'(err),          e.er);
            check("flip_cnt",   int'(flip_cnt),     e.fc);
            check("bounce_cnt", int'(bounce_cnt),   e.bc);
            check("s_locked",   int'(s_locked),     e.lk);
            check("s_bounce",   int'(s_bounce_det), e.bo);
            check("s_err",      int'(s_err),        e.er);
            check("s_flip_cnt", int'(s_flip_cnt),   sat3(e.fc));
            check("s_bcnt",     int'(s_bounce_cnt), sat3(e.bc));
        end
    endtask

    task automatic do_reset(input logic [3:0] mx, input logic [3:0] mn);
        exp_t e;
        rst_n     = 1'b0;
        out_v     = 4'd0;
        direction = 1'b1;
        enable    = 1'b1;
        max_v     = mx;
        min_v     = mn;
        mst   = M_SYNC;
        m_err = 0;
        m_fc  = 0;
        m_bc  = 0;
        e = '{lk: 0, fl: 0, bo: 0, er: 0, fc: 0, bc: 0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // ev is the hand classification of this step; it only matters while tracking.
    task automatic step(input logic [3:0] o, input logic d, input logic en,
                        input logic [3:0] mx, input logic [3:0] mn, input ev_t ev);
        exp_t e;
        int fl, bo;
        rst_n     = 1'b1;
        out_v     = o;
        direction = d;
        enable    = en;
        max_v     = mx;
        min_v     = mn;
        fl = 0;
        bo = 0;
        case (mst)
            M_SYNC: mst = M_TRACK;
            M_TRACK: begin
                if (ev == EV_F) begin
                    fl = 1;
                    m_fc++;
                end else if (ev == EV_B) begin
                    bo = 1;
                    m_bc++;
                end else if (ev == EV_E) begin
                    m_err = 1;
                    mst   = M_FAULT;
                end
            end
            default: begin
`ifdef PPM_RESYNC_EN
                mst = M_TRACK;
`else
                mst = M_FAULT;
`endif
            end
        endcase
        e = '{lk: (mst == M_TRACK) ? 1 : 0, fl: fl, bo: bo, er: m_err, fc: m_fc, bc: m_bc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Legal bouncing stream between mn and mx, starting from (mn, up).
    task automatic free_run(input logic [3:0] mx, input logic [3:0] mn, input int n);
        logic [3:0] cur;
        logic       dir;
        ev_t        ev;
        cur = mn;
        dir = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (dir && cur == mx) begin
                cur = cur - 4'd1; dir = 1'b0; ev = EV_B;
            end else if (!dir && cur == mn) begin
                cur = cur + 4'd1; dir = 1'b1; ev = EV_B;
            end else if (dir) begin
                cur = cur + 4'd1; ev = EV_N;
            end else begin
                cur = cur - 4'd1; ev = EV_N;
            end
            step(cur, dir, 1'b1, mx, mn, ev);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; direction = 1'b1;
        max_v = 4'd4; min_v = 4'd0; out_v = 4'd0;

        // Free run 0..4..0..1: two bounces, locked from the second edge.
        do_reset(4'd4, 4'd0);
        step(4'd0, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd4, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b0, 1'b1, 4'd4, 4'd0, EV_B);
        step(4'd2, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd0, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_B);

        // Mid-range flip at 2, then a bounce at 0.
        do_reset(4'd4, 4'd0);
        step(4'd0, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b0, 1'b1, 4'd4, 4'd0, EV_F);
        step(4'd0, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_B);

        // Hold rules: enable low, degenerate range, then an illegal move while held.
        step(4'd2, 1'b1, 1'b0, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b1, 1'b0, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b1, 1'b0, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b0, 1'b1, 4'd2, 4'd2, EV_F);
        step(4'd2, 1'b0, 1'b1, 4'd2, 4'd2, EV_N);
        step(4'd2, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd0, 1'b0, 1'b0, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b0, 1'b0, 4'd4, 4'd0, EV_E);
        step(4'd3, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);

        // Illegal jump 1->3 going up; reset also lands while possibly in FAULT.
        do_reset(4'd4, 4'd0);
        step(4'd0, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b1, 1'b1, 4'd4, 4'd0, EV_E);
        step(4'd3, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd4, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b0, 1'b1, 4'd4, 4'd0, EV_B);
        step(4'd2, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);

        // Build bounce=3, flip=1, err=1, then reset mid-run.
        do_reset(4'd4, 4'd0);
        step(4'd0, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd2, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b0, 1'b1, 4'd4, 4'd0, EV_F);
        step(4'd0, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_B);
        step(4'd2, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd4, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd3, 1'b0, 1'b1, 4'd4, 4'd0, EV_B);
        step(4'd2, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd0, 1'b0, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_B);
        step(4'd3, 1'b1, 1'b1, 4'd4, 4'd0, EV_E);
        do_reset(4'd4, 4'd0);
        step(4'd0, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);
        step(4'd1, 1'b1, 1'b1, 4'd4, 4'd0, EV_N);

        // Tight range 0..2: many bounces to drive the 2-bit counters into saturation.
        do_reset(4'd2, 4'd0);
        step(4'd0, 1'b1, 1'b1, 4'd2, 4'd0, EV_N);
        free_run(4'd2, 4'd0, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
